// File: rtl/inst_prefetch_pkg.sv
// inst_prefetch_pkg: shared constants and helpers for the instruction prefetch stage.
// Latency: n/a (package only).
// Backpressure: n/a. Defaults for start address, NOP encoding and queue depth.
package inst_prefetch_pkg;

    localparam int unsigned IPF_WORD = 32;

    localparam int unsigned IPF_DEPTH_DEF = 4;

    localparam logic [IPF_WORD-1:0] IPF_START_ADRS = 32'h0000_1000;

    localparam logic [IPF_WORD-1:0] IPF_NOP_INST = 32'h0000_0000;

    function automatic logic [IPF_WORD-1:0] next_word(input logic [IPF_WORD-1:0] adrs);
        return adrs + 32'd4;
    endfunction

endpackage

// File: rtl/inst_prefetch_fifo.sv
// inst_prefetch_fifo (ipf_fifo): DEPTH x 32 synchronous FIFO with push/pop/clear and occupancy count.
// Latency: pushed word visible at head the cycle after the push; head is combinational from storage.
// Backpressure: none internally; caller guarantees no push when full and no pop when empty.
// Ports: clk_cpu/reset (async active-high), push+wr_dat, pop, clear (wins over push/pop),
//        rd_dat (head word), count (occupancy 0..DEPTH).
module inst_prefetch_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = IPF_DEPTH_DEF,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic                clk_cpu,
    input  logic                reset,
    input  logic                push,
    input  logic [IPF_WORD-1:0] wr_dat,
    input  logic                pop,
    input  logic                clear,
    output logic [IPF_WORD-1:0] rd_dat,
    output logic [CW-1:0]       count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [IPF_WORD-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every use of the head word.
    always_ff @(posedge clk_cpu) begin
        if (push && !clear) mem_q[wr_ptr_q] <= wr_dat;
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// inst_prefetch: turns the core pc into in-order word reads and buffers up to DEPTH words for the core.
// Latency: zero-wait memory -> mem_req 1st cycle after reset, inst_valid 3rd, then one word per cycle.
// Backpressure: requests stop when buffered + outstanding + discarded reaches DEPTH; a request holds until granted.
// Ports: clk_cpu, reset (async high), pc/inst_ack from core, inst/inst_valid to core,
//        mem_req/mem_adrs/mem_gnt request channel, mem_rvalid/mem_rdata in-order responses.
// Optional: define IPF_PERF_EN to add saturating perf_hit / perf_stall / perf_flush counters.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int unsigned         DEPTH      = IPF_DEPTH_DEF,
    parameter logic [IPF_WORD-1:0] START_ADRS = IPF_START_ADRS
) (
    input  logic                clk_cpu,
    input  logic                reset,
    input  logic [IPF_WORD-1:0] pc,
    input  logic                inst_ack,
    output logic [IPF_WORD-1:0] inst,
    output logic                inst_valid,
    output logic                mem_req,
    output logic [IPF_WORD-1:0] mem_adrs,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [IPF_WORD-1:0] mem_rdata
`ifdef IPF_PERF_EN
    ,
    output logic [31:0]         perf_hit,
    output logic [31:0]         perf_stall,
    output logic [15:0]         perf_flush
`endif
);

    localparam int unsigned         CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]       ONE_C   = CW'(1);
    localparam logic [IPF_WORD-1:0] START_W = {START_ADRS[IPF_WORD-1:2], 2'b00};

    logic [CW-1:0]       count;
    logic [CW-1:0]       outstanding_q, outstanding_d;
    logic [CW-1:0]       discard_q, discard_d;
    logic [IPF_WORD-1:0] head_adrs_q, head_adrs_d;
    logic [IPF_WORD-1:0] fetch_adrs_q, fetch_adrs_d;
    logic [IPF_WORD-1:0] req_adrs_q, req_adrs_d;
    logic                req_held_q, req_held_d;
    logic                req_stale_q, req_stale_d;

    logic [IPF_WORD-1:0] pc_word;
    logic [IPF_WORD-1:0] fifo_head;
    logic [CW-1:0]       in_use;
    logic                redirect, pop, push, grant, req_stale;
    logic                resp_drop, resp_data;
    logic [1:0]          unused_pc_lsb;

    assign unused_pc_lsb = pc[1:0];
    assign pc_word       = {pc[IPF_WORD-1:2], 2'b00};

    always_comb begin
        redirect   = (pc_word != head_adrs_q);
        inst_valid = (count != '0) && !redirect;
        inst       = inst_valid ? fifo_head : IPF_NOP_INST;
        pop        = inst_valid && inst_ack;

        in_use   = count + outstanding_q + discard_q;
        mem_req  = !reset && (req_held_q || (in_use < DEPTH_C));
        // A held request keeps its own address even after fetch_adrs moves on a redirect.
        mem_adrs = req_held_q ? req_adrs_q : fetch_adrs_q;
        grant    = mem_req && mem_gnt;
        // Anything on the request port during a redirect belongs to the old stream.
        req_stale = redirect || (req_held_q && req_stale_q);

        resp_drop = mem_rvalid && (discard_q != '0);
        // Responses with nothing outstanding (e.g. from before a reset) are ignored.
        resp_data = mem_rvalid && (discard_q == '0) && (outstanding_q != '0);
        push      = resp_data && !redirect;

        discard_d     = discard_q - (resp_drop ? ONE_C : '0);
        outstanding_d = outstanding_q - (resp_data ? ONE_C : '0);
        head_adrs_d   = head_adrs_q;
        fetch_adrs_d  = fetch_adrs_q;

        if (redirect) begin
            discard_d     = discard_d + outstanding_d + (grant ? ONE_C : '0);
            outstanding_d = '0;
            head_adrs_d   = pc_word;
            fetch_adrs_d  = pc_word;
        end else begin
            if (grant) begin
                if (req_stale) begin
                    discard_d = discard_d + ONE_C;
                end else begin
                    outstanding_d = outstanding_d + ONE_C;
                    fetch_adrs_d  = next_word(fetch_adrs_q);
                end
            end
            if (pop) head_adrs_d = next_word(head_adrs_q);
        end

        req_held_d  = mem_req && !mem_gnt;
        req_adrs_d  = mem_adrs;
        req_stale_d = req_held_d && req_stale;
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
            discard_q     <= '0;
            head_adrs_q   <= START_W;
            fetch_adrs_q  <= START_W;
            req_adrs_q    <= START_W;
            req_held_q    <= 1'b0;
            req_stale_q   <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            head_adrs_q   <= head_adrs_d;
            fetch_adrs_q  <= fetch_adrs_d;
            req_adrs_q    <= req_adrs_d;
            req_held_q    <= req_held_d;
            req_stale_q   <= req_stale_d;
        end
    end

    inst_prefetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_cpu (clk_cpu),
        .reset   (reset),
        .push    (push),
        .wr_dat  (mem_rdata),
        .pop     (pop),
        .clear   (redirect),
        .rd_dat  (fifo_head),
        .count   (count)
    );

`ifdef IPF_PERF_EN
    logic [31:0] perf_hit_q, perf_hit_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_hit_d   = perf_hit_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (pop && (perf_hit_q != '1))          perf_hit_d   = perf_hit_q + 32'd1;
        if (!inst_valid && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
        if (redirect && (perf_flush_q != '1))   perf_flush_d = perf_flush_q + 16'd1;
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            perf_hit_q   <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_hit_q   <= perf_hit_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_hit   = perf_hit_q;
    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule
